// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: MULT/DIV results and done appear WIDTH+2 cycles after acceptance; MTHI/MTLO take 1 cycle.
// Backpressure: busy stalls the pipeline; a start seen while busy is dropped, never queued.
//
// Ports: clk, rst_n (async active-low); start/funct/a/b request; flush aborts the in-flight op;
//        busy = op in progress, done = one-cycle pulse on result write; hi/lo = architectural regs.

package types;
    localparam int WIDTH = 32;

    typedef enum logic [5:0] {
        FUNC_MFHI  = 6'h10,
        FUNC_MTHI  = 6'h11,
        FUNC_MFLO  = 6'h12,
        FUNC_MTLO  = 6'h13,
        FUNC_MULT  = 6'h18,
        FUNC_MULTU = 6'h19,
        FUNC_DIV   = 6'h1A,
        FUNC_DIVU  = 6'h1B
    } funct_type;
endpackage

module muldiv_unit #(
    parameter int WIDTH = types::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // acc: upper product half (multiply) or partial remainder (divide).
    // qr:  multiplier shifting out / lower product half, or dividend shifting out / quotient.
    // opb: multiplicand magnitude or divisor magnitude.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div0;

    // Request decode
    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic op_md, op_div_any, op_signed;
    assign op_mult    = (funct == types::FUNC_MULT);
    assign op_multu   = (funct == types::FUNC_MULTU);
    assign op_div     = (funct == types::FUNC_DIV);
    assign op_divu    = (funct == types::FUNC_DIVU);
    assign op_mthi    = (funct == types::FUNC_MTHI);
    assign op_mtlo    = (funct == types::FUNC_MTLO);
    assign op_div_any = op_div | op_divu;
    assign op_md      = op_mult | op_multu | op_div_any;
    assign op_signed  = op_mult | op_div;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sign_a = op_signed & a[WIDTH-1];
    assign sign_b = op_signed & b[WIDTH-1];
    assign a_mag  = sign_a ? (~a + 1'b1) : a;
    assign b_mag  = sign_b ? (~b + 1'b1) : b;

    // One iteration of each algorithm
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ok;
    assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc, qr[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_ok    = ~div_diff[WIDTH];

    // Sign correction applied in FIXUP.
    // With a zero divisor the magnitude datapath leaves |a| in acc, so the normal
    // remainder sign rule restores the raw dividend; only the quotient is forced.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;
    assign prod     = {acc, qr};
    assign prod_fix = neg_res ? (~prod + 1'b1) : prod;
    assign quot_fix = neg_res ? (~qr + 1'b1) : qr;
    assign rem_fix  = neg_rem ? (~acc + 1'b1) : acc;
    assign res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? (div0 ? {WIDTH{1'b1}} : quot_fix) : prod_fix[WIDTH-1:0];

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            qr      <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // flush in IDLE swallows any same-cycle request
                    if (start && !flush) begin
                        if (op_mthi) hi <= a;
                        if (op_mtlo) lo <= a;
                        if (op_md) begin
                            state   <= S_CALC;
                            cnt     <= '0;
                            acc     <= '0;
                            is_div  <= op_div_any;
                            neg_res <= sign_a ^ sign_b;
                            neg_rem <= sign_a & op_div_any;
                            div0    <= op_div_any && (b == '0);
                            if (op_div_any) begin
                                qr  <= a_mag;
                                opb <= b_mag;
                            end else begin
                                qr  <= b_mag;
                                opb <= a_mag;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], div_ok};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of MULT/DIV vectors run back-to-back, plus
// hand sequences for MTHI/MTLO, start-while-busy, flush and mid-operation reset.
// Cycle k means the k-th clock period after the edge that accepted the request.

module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .a     (op_a),
        .b     (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one MULT/DIV and follow it to its done cycle (returns sampled in cycle W+2).
    // If intr_cyc is nonzero, a second request is driven during that busy cycle.
    task automatic run_op(input string nm, input logic [5:0] f, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int intr_cyc, input logic [5:0] intr_f, input logic [W-1:0] intr_a);
        int bad;
        bad   = 0;
        start = 1'b1;
        funct = f;
        op_a  = av;
        op_b  = bv;
        step();
        start = 1'b0;
        for (int c = 1; c <= W + 1; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (c == intr_cyc) begin
                start = 1'b1;
                funct = intr_f;
                op_a  = intr_a;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
        chk({nm, "_busy_window_errs"}, bad, 0);
        chk({nm, "_done"}, {31'd0, done}, 1);
        chk({nm, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        funct = '0;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;

        vecs[0]  = '{types::FUNC_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{types::FUNC_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{types::FUNC_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{types::FUNC_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{types::FUNC_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{types::FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{types::FUNC_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7]  = '{types::FUNC_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{types::FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{types::FUNC_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{types::FUNC_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{types::FUNC_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        vecs[12] = '{types::FUNC_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        // Reset state
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        step();

        // Vector table, each op issued in the previous op's done cycle
        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 0, 6'h00, '0);
        end
        step();
        chk("done_one_cycle", {31'd0, done}, 0);

        // MTHI / MTLO single-cycle writes
        start = 1'b1; funct = types::FUNC_MTHI; op_a = 32'h12345678;
        step();
        start = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 0);
        chk("mthi_done", {31'd0, done}, 0);
        start = 1'b1; funct = types::FUNC_MTLO; op_a = 32'h9ABCDEF0;
        step();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);

        // Unsupported funct is ignored
        start = 1'b1; funct = types::FUNC_MFHI; op_a = 32'h0;
        step();
        start = 1'b0;
        chk("mfhi_ignored_busy", {31'd0, busy}, 0);
        chk("mfhi_ignored_hi", hi, 32'h12345678);

        // MTLO during a MULT is dropped
        run_op("mult_mtlo_intr", types::FUNC_MULT, 32'd5, 32'd6, 32'd0, 32'd30,
               5, types::FUNC_MTLO, 32'hDEADBEEF);

        // Flush in IDLE suppresses start
        start = 1'b1; flush = 1'b1; funct = types::FUNC_MTHI; op_a = 32'h11111111;
        step();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", hi, 32'd0);
        chk("idle_flush_busy", {31'd0, busy}, 0);

        // Flush mid-MULT leaves HI/LO untouched
        start = 1'b1; funct = types::FUNC_MTHI; op_a = 32'hA5A5A5A5;
        step();
        funct = types::FUNC_MTLO;
        step();
        funct = types::FUNC_MULT; op_a = 32'd3; op_b = 32'd4;
        step();
        start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            if (busy !== 1'b1) bad++;
            if (c == 10) flush = 1'b1;
            step();
        end
        flush = 1'b0;
        chk("flush_busy_before", bad, 0);
        chk("flush_busy_c11", {31'd0, busy}, 0);
        bad = 0;
        for (int c = 0; c < W + 4; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        chk("flush_no_done", bad, 0);
        chk("flush_hi", hi, 32'hA5A5A5A5);
        chk("flush_lo", lo, 32'hA5A5A5A5);
        run_op("after_flush", types::FUNC_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0, 6'h00, '0);

        // Asynchronous reset at cycle 5 of a DIV
        start = 1'b1; funct = types::FUNC_DIV; op_a = 32'd100; op_b = 32'd7;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < W + 6; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        chk("arst_no_done_after", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with the architectural HI/LO register pair for the 32-bit MIPS-subset core. It sits beside the ALU in the execute stage and consumes R-type `funct_type` codes FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI and FUNC_MTLO from the decoder. It exposes HI/LO continuously so the writeback mux can serve FUNC_MFHI/FUNC_MFLO. `busy` is the stall request to the pipeline control.

## Interface
- WIDTH, default `types::WIDTH` (32): operand, HI and LO width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request valid; sampled only when `busy`=0.
- funct  in  6  `types::funct_type` code qualifying `start`.
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  operation in progress; pipeline must stall on MFHI/MFLO/new muldiv.
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, CALC, FIXUP. `busy` = (state != IDLE).
- IDLE + start + funct in {MULT, MULTU, DIV, DIVU}:
  - latch operands;
  - signed ops take absolute values and record result signs;
  - clear the iteration counter;
  - go to CALC.
- IDLE + start + MTHI: `hi` <= a. MTLO: `lo` <= a. Single cycle, no `busy`, no `done`.
- start with any other funct: ignored. start while busy: ignored, no queueing.
- CALC, one bit per cycle for exactly WIDTH cycles, then FIXUP:
  - multiply: shift-add over the 2*WIDTH product;
  - divide: restoring, with a WIDTH+1-bit partial remainder.
- FIXUP:
  - apply sign correction:
    - product negated if the operand signs differ;
    - quotient negated if the signs differ;
    - remainder takes the dividend's sign.
  - write `hi`/`lo`; assert `done` next cycle; return to IDLE.
- Result mapping:
  - MULT/MULTU: `hi` = product[2W-1:W], `lo` = product[W-1:0].
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
- Divide by zero, DIV and DIVU: `lo` = all ones, `hi` = a (raw dividend). No sign fixup.
- Signed overflow (most-negative / -1): `lo` = most-negative value, `hi` = 0. This falls out of the magnitude datapath; no special case.
- flush:
  - in CALC or FIXUP: go to IDLE next edge; `hi`/`lo` unchanged; no `done`.
  - in IDLE: no effect, and suppresses a same-cycle start.
- rst_n low, at any time including mid-operation: state IDLE; `hi`, `lo` = 0; `busy`, `done` = 0; counter and datapath cleared.

## Timing
- Start accepted at edge T0.
- `busy` high in cycles 1..WIDTH+1: WIDTH cycles in CALC, 1 in FIXUP.
- `hi`/`lo` take new values and `done`=1 in cycle WIDTH+2, i.e. cycle 34 for WIDTH=32. `busy`=0 in that cycle.
- A new start is accepted in the `done` cycle, giving back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO: register visible in the cycle after acceptance.
- `hi`/`lo` are register outputs with no combinational path from inputs. MFHI issued in the `done` cycle reads the new value.
- `done` is registered and high for exactly one cycle. `done` and `busy` are never high together.

## Test plan
- MULT a=0xFFFFFFFE, b=0x00000003 -> `busy` cycles 1..33; cycle 34: `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 -> hi=0x12345678 next cycle, `busy`/`done` stay 0. MTLO issued at cycle 5 of a MULT -> ignored; MULT result intact.
- Preload hi=lo=0xA5A5A5A5, start MULT 3*4, flush at cycle 10 -> `busy`=0 at cycle 11, no `done`, hi/lo still 0xA5A5A5A5. A fresh MULTU 3*4 then yields lo=12, hi=0.
- rst_n low for 1 cycle at cycle 5 of a DIV -> immediately `busy`=0, `done`=0, hi=lo=0. `done` does not pulse afterwards.
